// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
//   INSTR_W        instruction word width
//   FETCH_ADDR_W   default PC width
//   fetch_state_t  request-channel FSM states
//   fetch_entry_t  {instr, pc} pair held in the instruction queue
//   sat_add32      32-bit saturating add, used by the FETCH_PERF_EN counters
package fetch_pkg;

  localparam int unsigned INSTR_W      = 32;
  localparam int unsigned FETCH_ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DROP
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0]      instr;
    logic [FETCH_ADDR_W-1:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Registered FIFO holding fetched {instr, pc} entries.
//   clk, rst   clock / synchronous active-high reset
//   flush      empties the queue; overrides same-cycle push and pop
//   push       write push_data at the tail
//   pop        advance the head (ignored when empty)
//   pop_data   head entry
//   count      number of valid entries (0..DEPTH)
module fetch_fifo #(
  parameter int unsigned W     = 64,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     push_data,
  output logic [W-1:0]     pop_data,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign do_pop   = pop && (count != '0);
  // A push at full is only legal when the head leaves in the same cycle.
  assign do_push  = push && ((count != CNT_W'(DEPTH)) || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues single-outstanding
// word reads to instruction memory, queues responses and presents
// {instr, pc, pc+4} to decode. Redirects flush the queue and discard any
// stale in-flight response.
// Ports:
//   clk, rst                      clock / synchronous active-high reset
//   imem_req_valid/ready/addr     fetch request channel
//   imem_rsp_valid/data           in-order response, one per accepted request
//   redirect_valid/pc             branch/jump restart
//   instr_valid/ready             head handshake to decode
//   instr, instr_pc, instr_pcplus4 head contents
// Optional (macro FETCH_PERF_EN): perf_fetched, perf_flushed, perf_stall
// 32-bit saturating event counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       DEPTH    = 4
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [31:0]        imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [31:0]        instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [ADDR_W-1:0]  instr_pcplus4
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_flushed,
  output logic [31:0]        perf_stall
`endif
);

  localparam int unsigned      CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned      ENT_W = INSTR_W + ADDR_W;
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

  fetch_state_t      state;
  logic [ADDR_W-1:0] fetch_pc, req_pc;
  logic [CNT_W-1:0]  fifo_count, count_after_push;
  logic [ENT_W-1:0]  head;
  logic              push, pop_fire;

  assign pop_fire         = instr_valid && instr_ready;
  assign push             = (state == WAIT) && imem_rsp_valid && !redirect_valid;
  assign count_after_push = fifo_count + CNT_W'(1) - CNT_W'(pop_fire);

  fetch_fifo #(.W(ENT_W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .pop       (pop_fire),
    .push_data ({imem_rsp_data, req_pc}),
    .pop_data  (head),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & ~ADDR_W'(3);
      // Anything already accepted must have its response swallowed; a
      // response arriving this very cycle is that response.
      unique case (state)
        IDLE:       state <= IDLE;
        REQ:        state <= imem_req_ready ? DROP : IDLE;
        WAIT, DROP: state <= imem_rsp_valid ? IDLE : DROP;
      endcase
    end else begin
      unique case (state)
        IDLE: if (fifo_count < FULL) state <= REQ;
        REQ: begin
          if (imem_req_ready) begin
            req_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + ADDR_W'(4);
            state    <= WAIT;
          end
        end
        WAIT: if (imem_rsp_valid) state <= (count_after_push < FULL) ? REQ : IDLE;
        DROP: if (imem_rsp_valid) state <= IDLE;
      endcase
    end
  end

  assign imem_req_valid = (state == REQ);
  assign imem_req_addr  = fetch_pc;
  assign instr_valid    = (fifo_count != '0);
  assign instr          = instr_valid ? head[ENT_W-1:ADDR_W] : '0;
  assign instr_pc       = instr_valid ? head[ADDR_W-1:0] : '0;
  assign instr_pcplus4  = instr_valid ? head[ADDR_W-1:0] + ADDR_W'(4) : '0;

`ifdef FETCH_PERF_EN
  logic        drop_now;
  logic [31:0] flush_inc;

  assign drop_now  = imem_rsp_valid && ((state == DROP) || ((state == WAIT) && redirect_valid));
  assign flush_inc = (redirect_valid ? 32'(fifo_count) : 32'd0) + 32'(drop_now);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
      perf_stall   <= '0;
    end else begin
      if (push) perf_fetched <= sat_add32(perf_fetched, 32'd1);
      perf_flushed <= sat_add32(perf_flushed, flush_inc);
      if (instr_ready && !instr_valid) perf_stall <= sat_add32(perf_stall, 32'd1);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc, instr_pcplus4;

  logic        w_req_valid, w_req_ready;
  logic [31:0] w_req_addr;
  logic        w_rsp_valid;
  logic [31:0] w_rsp_data;
  logic        w_redirect_valid;
  logic [31:0] w_redirect_pc;
  logic        w_instr_valid, w_instr_ready;
  logic [31:0] w_instr, w_instr_pc, w_instr_pcplus4;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_flushed, perf_stall;
  logic [31:0] w_perf_fetched, w_perf_flushed, w_perf_stall;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic        auto_mem;
  int unsigned rsp_lat;
  logic        busy;
  int unsigned delay;
  logic [31:0] lat_addr;
  logic [31:0] req_log[$];

  fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .instr_pcplus4(instr_pcplus4)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed), .perf_stall(perf_stall)
`endif
  );

  fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut_w (
    .clk(clk), .rst(rst),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_req_addr(w_req_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
    .instr_valid(w_instr_valid), .instr_ready(w_instr_ready),
    .instr(w_instr), .instr_pc(w_instr_pc), .instr_pcplus4(w_instr_pcplus4)
`ifdef FETCH_PERF_EN
    , .perf_fetched(w_perf_fetched), .perf_flushed(w_perf_flushed), .perf_stall(w_perf_stall)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  // Memory model for the main instance: fixed latency, logs accepted addresses.
  initial begin
    busy = 1'b0; delay = 0; lat_addr = '0;
    forever begin
      @(negedge clk); #3;
      if (!auto_mem) begin
        busy = 1'b0;
      end else if (rst) begin
        busy = 1'b0;
        imem_rsp_valid = 1'b0;
      end else begin
        if (busy && delay == 1) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = word_of(lat_addr);
          busy = 1'b0;
        end else begin
          imem_rsp_valid = 1'b0;
          if (busy) delay--;
        end
        if (imem_req_valid && imem_req_ready) begin
          busy = 1'b1;
          delay = rsp_lat;
          lat_addr = imem_req_addr;
          req_log.push_back(imem_req_addr);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(negedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b0;
    imem_req_ready = 1'b0;
    rsp_lat = 1;
    if (!auto_mem) imem_rsp_valid = 1'b0;
    step(2);
    req_log.delete();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h80;
    instr_ready = 1'b0;
    imem_req_ready = 1'b0;
    step(3);
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); end
    total++; if (imem_req_addr !== 32'h0) begin bad++; $display("FAIL rst_req_addr: got %h want 00000000", imem_req_addr); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_instr_valid: got %b want 0", instr_valid); end
    total++; if (instr !== 32'h0) begin bad++; $display("FAIL rst_instr: got %h want 00000000", instr); end
    total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL rst_instr_pc: got %h want 00000000", instr_pc); end
    total++; if (instr_pcplus4 !== 32'h0) begin bad++; $display("FAIL rst_pcplus4: got %h want 00000000", instr_pcplus4); end
    total++; if (w_req_addr !== 32'hFFFF_FFF8) begin bad++; $display("FAIL rst_w_req_addr: got %h want fffffff8", w_req_addr); end
    redirect_valid = 1'b0;
    rst = 1'b0;
    step(1);
    total++; if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL post_rst_req_valid: got %b want 1", imem_req_valid); end
    total++; if (imem_req_addr !== 32'h0) begin bad++; $display("FAIL post_rst_req_addr: got %h want 00000000", imem_req_addr); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc [3];
    int k, c_prev;
    exp_pc = '{32'h0, 32'h4, 32'h8};
    k = 0; c_prev = 0;
    do_reset();
    imem_req_ready = 1'b1;
    instr_ready = 1'b1;
    for (int c = 0; c < 40 && k < 3; c++) begin
      if (instr_valid) begin
        total++; if (instr_pc !== exp_pc[k]) begin bad++; $display("FAIL stream_pc[%0d]: got %h want %h", k, instr_pc, exp_pc[k]); end
        total++; if (instr_pcplus4 !== exp_pc[k] + 32'd4) begin bad++; $display("FAIL stream_pcplus4[%0d]: got %h want %h", k, instr_pcplus4, exp_pc[k] + 32'd4); end
        total++; if (instr !== word_of(exp_pc[k])) begin bad++; $display("FAIL stream_instr[%0d]: got %h want %h", k, instr, word_of(exp_pc[k])); end
        if (k > 0) begin
          total++; if (c - c_prev != 2) begin bad++; $display("FAIL stream_spacing[%0d]: got %0d want 2", k, c - c_prev); end
        end
        c_prev = c;
        k++;
      end
      step(1);
    end
    total++; if (k != 3) begin bad++; $display("FAIL stream_count: got %0d want 3", k); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (req_log.size() <= i) begin bad++; $display("FAIL stream_req[%0d]: got none want %h", i, exp_pc[i]); end
      else if (req_log[i] !== exp_pc[i]) begin bad++; $display("FAIL stream_req[%0d]: got %h want %h", i, req_log[i], exp_pc[i]); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    imem_req_ready = 1'b1;
    step(30);
    total++; if (req_log.size() != 4) begin bad++; $display("FAIL bp_req_count: got %0d want 4", req_log.size()); end
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL bp_req_valid: got %b want 0", imem_req_valid); end
    total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL bp_instr_valid: got %b want 1", instr_valid); end
    total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL bp_head_pc: got %h want 00000000", instr_pc); end
    total++; if (instr !== word_of(32'h0)) begin bad++; $display("FAIL bp_head_instr: got %h want %h", instr, word_of(32'h0)); end
    step(3);
    total++; if (instr !== word_of(32'h0)) begin bad++; $display("FAIL bp_head_stable: got %h want %h", instr, word_of(32'h0)); end
    instr_ready = 1'b1;
    step(1);
    instr_ready = 1'b0;
    total++; if (instr_pc !== 32'h4) begin bad++; $display("FAIL bp_pop_pc: got %h want 00000004", instr_pc); end
    total++; if (instr_pcplus4 !== 32'h8) begin bad++; $display("FAIL bp_pop_pcplus4: got %h want 00000008", instr_pcplus4); end
    step(10);
    total++; if (req_log.size() != 5) begin bad++; $display("FAIL bp_refill_count: got %0d want 5", req_log.size()); end
    else begin
      total++; if (req_log[4] !== 32'h10) begin bad++; $display("FAIL bp_refill_addr: got %h want 00000010", req_log[4]); end
    end
  endtask

  task automatic test_redirect_wait();
    int n;
    do_reset();
    rsp_lat = 2;
    imem_req_ready = 1'b1;
    n = 0;
    while (req_log.size() < 3 && n < 40) begin step(1); n++; end
    total++; if (req_log.size() != 3) begin bad++; $display("FAIL rw_third_req: got %0d reqs want 3", req_log.size()); end
    else begin
      total++; if (req_log[2] !== 32'h8) begin bad++; $display("FAIL rw_third_addr: got %h want 00000008", req_log[2]); end
    end
    total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL rw_pre_valid: got %b want 1", instr_valid); end
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    step(1);
    redirect_valid = 1'b0;
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rw_flushed: got %b want 0", instr_valid); end
    total++; if (imem_req_addr !== 32'h40) begin bad++; $display("FAIL rw_fetch_pc: got %h want 00000040", imem_req_addr); end
    n = 0;
    while (!instr_valid && n < 40) begin step(1); n++; end
    total++; if (instr_pc !== 32'h40) begin bad++; $display("FAIL rw_first_pc: got %h want 00000040", instr_pc); end
    total++; if (instr !== word_of(32'h40)) begin bad++; $display("FAIL rw_first_instr: got %h want %h", instr, word_of(32'h40)); end
    total++; if (req_log.size() < 4) begin bad++; $display("FAIL rw_next_req: got %0d reqs want 4", req_log.size()); end
    else begin
      total++; if (req_log[3] !== 32'h40) begin bad++; $display("FAIL rw_next_addr: got %h want 00000040", req_log[3]); end
    end
  endtask

  task automatic test_redirect_req();
    int n;
    do_reset();
    step(3);
    total++; if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL rq_stalled_valid: got %b want 1", imem_req_valid); end
    total++; if (imem_req_addr !== 32'h0) begin bad++; $display("FAIL rq_stalled_addr: got %h want 00000000", imem_req_addr); end
    redirect_valid = 1'b1;
    redirect_pc = 32'h103;
    step(1);
    redirect_valid = 1'b0;
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rq_withdrawn: got %b want 0", imem_req_valid); end
    total++; if (imem_req_addr !== 32'h100) begin bad++; $display("FAIL rq_aligned_addr: got %h want 00000100", imem_req_addr); end
    step(1);
    total++; if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL rq_reissue_valid: got %b want 1", imem_req_valid); end
    imem_req_ready = 1'b1;
    n = 0;
    while (!instr_valid && n < 40) begin step(1); n++; end
    total++; if (instr_pc !== 32'h100) begin bad++; $display("FAIL rq_first_pc: got %h want 00000100", instr_pc); end
    total++; if (req_log.size() == 0) begin bad++; $display("FAIL rq_first_req: got none want 00000100"); end
    else if (req_log[0] !== 32'h100) begin bad++; $display("FAIL rq_first_req: got %h want 00000100", req_log[0]); end
  endtask

  task automatic test_redirect_collide();
    int n;
    auto_mem = 1'b0;
    do_reset();
    imem_req_ready = 1'b1;
    n = 0;
    while (!imem_req_valid && n < 20) begin step(1); n++; end
    total++; if (imem_req_addr !== 32'h0) begin bad++; $display("FAIL rc_req0: got %h want 00000000", imem_req_addr); end
    step(1);
    imem_rsp_valid = 1'b1;
    imem_rsp_data = word_of(32'h0);
    step(1);
    imem_rsp_valid = 1'b0;
    total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL rc_pre_valid: got %b want 1", instr_valid); end
    total++; if (imem_req_addr !== 32'h4) begin bad++; $display("FAIL rc_req1: got %h want 00000004", imem_req_addr); end
    step(1);
    instr_ready = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data = word_of(32'h4);
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    step(1);
    instr_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rc_empty: got %b want 0", instr_valid); end
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rc_idle: got %b want 0", imem_req_valid); end
    total++; if (imem_req_addr !== 32'h200) begin bad++; $display("FAIL rc_target: got %h want 00000200", imem_req_addr); end
    step(1);
    total++; if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL rc_restart: got %b want 1", imem_req_valid); end
    step(1);
    imem_rsp_valid = 1'b1;
    imem_rsp_data = word_of(32'h200);
    step(1);
    imem_rsp_valid = 1'b0;
    total++; if (instr_pc !== 32'h200) begin bad++; $display("FAIL rc_new_pc: got %h want 00000200", instr_pc); end
    total++; if (instr !== word_of(32'h200)) begin bad++; $display("FAIL rc_new_instr: got %h want %h", instr, word_of(32'h200)); end
    auto_mem = 1'b1;
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [3];
    logic [31:0] exp_p4 [3];
    int n;
    exp_pc = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    exp_p4 = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (!w_req_valid && n < 20) begin step(1); n++; end
      total++; if (w_req_addr !== exp_pc[i]) begin bad++; $display("FAIL wrap_req[%0d]: got %h want %h", i, w_req_addr, exp_pc[i]); end
      w_req_ready = 1'b1;
      step(1);
      w_req_ready = 1'b0;
      w_rsp_valid = 1'b1;
      w_rsp_data = word_of(exp_pc[i]);
      step(1);
      w_rsp_valid = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      total++; if (w_instr_pc !== exp_pc[i]) begin bad++; $display("FAIL wrap_pc[%0d]: got %h want %h", i, w_instr_pc, exp_pc[i]); end
      total++; if (w_instr_pcplus4 !== exp_p4[i]) begin bad++; $display("FAIL wrap_pcplus4[%0d]: got %h want %h", i, w_instr_pcplus4, exp_p4[i]); end
      total++; if (w_instr !== word_of(exp_pc[i])) begin bad++; $display("FAIL wrap_instr[%0d]: got %h want %h", i, w_instr, word_of(exp_pc[i])); end
      w_instr_ready = 1'b1;
      step(1);
      w_instr_ready = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    auto_mem = 1'b1;
    rsp_lat = 1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b0;
    w_req_ready = 1'b0;
    w_rsp_valid = 1'b0;
    w_rsp_data = '0;
    w_redirect_valid = 1'b0;
    w_redirect_pc = '0;
    w_instr_ready = 1'b0;
    step(1);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_req();
    test_redirect_collide();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
